// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
// Each operation takes WIDTH/2+1 iterations in both signed and unsigned mode.
module radix4_booth_seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned N     = WIDTH / 2 + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH / 2 + 2);
    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned AW    = WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [EW-1:0]      xreg;
    logic [EW-1:0]      mreg;
    logic               yprev;
    logic [AW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;

    logic               load_c;
    logic               last_c;
    logic [EW-1:0]      x_ext_c;
    logic [EW-1:0]      y_ext_c;
    logic [AW-1:0]      x1_c;
    logic [AW-1:0]      x2_c;
    logic [AW-1:0]      pp_c;
    logic [AW-1:0]      sum_c;
    logic [AW-1:0]      acc_nx_c;
    logic [EW-1:0]      mreg_nx_c;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; load_c marks an accepted start
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                    load_c     = 1'b1;
                end
            end
            CALC: begin
                if (last_c) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = CALC;
                    load_c     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand extension, Booth digit selection and one shift-add step
    always_comb begin
        x_ext_c = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
        y_ext_c = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
        last_c  = (cnt == CNT_W'(N - 1));
        x1_c    = {xreg[EW-1], xreg};
        x2_c    = {xreg, 1'b0};
        pp_c    = '0;
        case ({mreg[1:0], yprev})
            3'b001, 3'b010: pp_c = x1_c;
            3'b011:         pp_c = x2_c;
            3'b100:         pp_c = ~x2_c + AW'(1);
            3'b101, 3'b110: pp_c = ~x1_c + AW'(1);
            default:        pp_c = '0;
        endcase
        sum_c     = acc + pp_c;
        acc_nx_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
        mreg_nx_c = {sum_c[1:0], mreg[EW-1:2]};
    end

    // Datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            xreg  <= '0;
            mreg  <= '0;
            yprev <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
            if (load_c) begin
                xreg  <= x_ext_c;
                mreg  <= y_ext_c;
                yprev <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                acc   <= acc_nx_c;
                mreg  <= mreg_nx_c;
                yprev <= mreg[1];
                cnt   <= cnt + CNT_W'(1);
                if (last_c) out <= {acc_nx_c[WIDTH-3:0], mreg_nx_c};
            end
        end
    end

endmodule

// File: doc/radix4_booth_seq_mult.md
Name: radix4_booth_seq_mult

Overview:
Parametrised sequential radix-4 Booth multiplier. It is the next generation of the fixed 32-bit radix4booth unit, used in the FloatMultiplier datapath for the mantissa product. New over the 32-bit unit:
- generic operand width
- signed/unsigned mode per operation
- explicit start/busy/done handshake
- fixed, documented latency

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH/2+2), iteration counter width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  request; sampled only when not busy
signed_mode  in  1  1: x,y two's complement; 0: unsigned; captured with start
x  in  WIDTH  multiplicand, captured with start
y  in  WIDTH  multiplier, captured with start
busy  out  1  high while iterating
done  out  1  one-cycle pulse; out valid
out  out  2*WIDTH  product, held until next accepted start or reset

Behaviour:
- Reset: on a rising clk edge with reset==0:
  - state=IDLE; busy=0, done=0, out=0; internal accumulator, operand and counter registers cleared.
  - Reset overrides start and an operation in flight; the partial result is discarded.
- Operand extension:
  - Operands are internally extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - N = WIDTH/2+1 iterations in both modes, so latency does not depend on mode.
- Per iteration:
  - Examine a 3-bit window of the extended multiplier (with implicit y[-1]=0).
  - Booth digit d in {-2,-1,0,+1,+2}.
  - Add d*X (WIDTH+3 bit sign-extended partial product) into the upper accumulator.
  - Arithmetic-shift the {accumulator, multiplier} pair right by 2.
- Result: out = low 2*WIDTH bits of the final product. It is exact for all inputs in both modes.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 -> capture x, y, signed_mode; counter=0; go to CALC.
  - CALC: busy=1; one iteration per edge; after the Nth iteration edge -> DONE, out registered, done=1.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 -> new capture, go to CALC (back-to-back accepted).
    - Otherwise -> IDLE.
- Latency: the edge that samples start is edge 0; done and the new out appear after edge N. For WIDTH=32 that is 17 cycles; for WIDTH=8 it is 5 cycles.
- Throughput: one product per N+1 cycles when start is held high.
- start while busy=1 is ignored. Changes to x, y or signed_mode during CALC have no effect.
- out only changes on the done edge or on reset. It keeps the previous product through IDLE and CALC.
- done and busy are never high together.

Test Plan:
1. WIDTH=32, signed. x=4, y=2 -> done after 17 cycles, out=64'd8. Then x=8, y=-2 (0xFFFFFFFE) -> out=0xFFFFFFFF_FFFFFFF0. Then x=-12, y=-2 -> out=64'd24.
2. WIDTH=32 corners.
   - Signed 0x80000000 * 0x80000000 -> out=0x40000000_00000000.
   - Signed 0x80000000 * 0x7FFFFFFF -> out=0xC0000000_80000000.
   - x=-2, y=0 -> out=0.
3. WIDTH=32, unsigned. 0xFFFFFFFF * 0xFFFFFFFF -> out=0xFFFFFFFE_00000001. Same operands signed -> out=64'd1.
4. Handshake.
   - Pulse start; re-pulse start with different operands at cycle 5 (busy=1) -> ignored, first product returned.
   - Hold start high -> a second done exactly 18 cycles after the first.
   - Busy and done are never coincident.
5. Reset mid-operation. Drive reset=0 for one edge at cycle 8 of CALC -> next cycle busy=0, done=0, out=0, and no done pulse follows. A new start then yields the correct product.
6. WIDTH=8 instance, latency 5.
   - Signed -128 * -128 -> 16'h4000.
   - Signed -128 * 127 -> 16'hC080.
   - Unsigned 255 * 255 -> 16'hFE01.
   - Exhaustive 65536-pair sweep in both modes against a reference model -> zero mismatches.
